// File: rtl/event_sync_collector.sv
// Multi-channel event collector: synchronises foreign-domain event levels into clk50, latches
// rising edges as sticky pending flags, raises a masked priority irq and counts missed events.
module event_sync_collector #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 8,
    localparam int unsigned IDW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk50,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       evt_async,
    input  logic [NUM_CH-1:0]       irq_mask,
    input  logic                    ack_valid,
    input  logic [IDW-1:0]          ack_id,
    input  logic                    miss_clr,
    output logic [NUM_CH-1:0]       pending,
    output logic                    irq,
    output logic [IDW-1:0]          irq_id,
    output logic                    ack_err,
    output logic [NUM_CH*CNT_W-1:0] miss_cnt
);

    logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
    logic [NUM_CH-1:0] lvl;
    logic [NUM_CH-1:0] lvl_prev_q;
    logic [NUM_CH-1:0] rise;

    logic [NUM_CH-1:0] pending_q, pending_d;
    logic              ack_err_q, ack_err_d;
    logic [CNT_W-1:0]  cnt_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_d [NUM_CH];

    logic [NUM_CH-1:0] ack_sel;
    logic [NUM_CH-1:0] ack_hit;
    logic [NUM_CH-1:0] miss_inc;
    logic [NUM_CH-1:0] irq_src;

    assign lvl  = sync_q[SYNC_STAGES-1];
    assign rise = lvl & ~lvl_prev_q;

    // Out-of-range ack_id decodes to no channel, so it falls into the invalid-ack path.
    always_comb begin
        ack_sel = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            ack_sel[i] = ack_valid && (ack_id == IDW'(i));
        end
    end

    assign ack_hit   = ack_sel & pending_q;
    assign ack_err_d = ack_valid && (ack_hit == '0);
    assign miss_inc  = rise & pending_q & ~ack_hit;
    // A rise wins over a same-cycle ack: the old event is consumed, the new one latched.
    assign pending_d = rise | (pending_q & ~ack_hit);

    always_comb begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (miss_clr) begin
                cnt_d[i] = '0;
            end else if (miss_inc[i] && (cnt_q[i] != {CNT_W{1'b1}})) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk50) begin
        if (reset) begin
            for (int unsigned k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
            lvl_prev_q <= '0;
            pending_q  <= '0;
            ack_err_q  <= 1'b0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= evt_async;
            for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
            lvl_prev_q <= lvl;
            pending_q  <= pending_d;
            ack_err_q  <= ack_err_d;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign pending = pending_q;
    assign ack_err = ack_err_q;
    assign irq_src = pending_q & ~irq_mask;
    assign irq     = |irq_src;

    // Scan from the top so the lowest-index active channel is the last assignment.
    always_comb begin
        irq_id = '0;
        for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
            if (irq_src[i]) begin
                irq_id = IDW'(i);
            end
        end
    end

    always_comb begin
        miss_cnt = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            miss_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
        end
    end

endmodule

// File: tb/tb_event_sync_collector.sv
// Bench for event_sync_collector: a 4-channel/8-bit instance and a 3-channel/2-bit instance,
// checked every cycle against a rule-level reference model, plus directed scenario checks.
module tb_event_sync_collector;

    localparam int SYNC = 2;

    logic clk50 = 1'b0;
    always #5 clk50 = ~clk50;

    logic       reset;
    logic [3:0] evt  [2];
    logic [3:0] mask [2];
    logic       av   [2];
    logic [1:0] aid  [2];
    logic       clr  [2];

    logic [3:0]  pend_a;
    logic [2:0]  pend_b;
    logic        irq_a, irq_b;
    logic [1:0]  id_a, id_b;
    logic        err_a, err_b;
    logic [31:0] miss_a;
    logic [5:0]  miss_b;

    event_sync_collector #(
        .NUM_CH      (4),
        .SYNC_STAGES (SYNC),
        .CNT_W       (8)
    ) u_dut_a (
        .clk50     (clk50),
        .reset     (reset),
        .evt_async (evt[0]),
        .irq_mask  (mask[0]),
        .ack_valid (av[0]),
        .ack_id    (aid[0]),
        .miss_clr  (clr[0]),
        .pending   (pend_a),
        .irq       (irq_a),
        .irq_id    (id_a),
        .ack_err   (err_a),
        .miss_cnt  (miss_a)
    );

    event_sync_collector #(
        .NUM_CH      (3),
        .SYNC_STAGES (SYNC),
        .CNT_W       (2)
    ) u_dut_b (
        .clk50     (clk50),
        .reset     (reset),
        .evt_async (evt[1][2:0]),
        .irq_mask  (mask[1][2:0]),
        .ack_valid (av[1]),
        .ack_id    (aid[1]),
        .miss_clr  (clr[1]),
        .pending   (pend_b),
        .irq       (irq_b),
        .irq_id    (id_b),
        .ack_err   (err_b),
        .miss_cnt  (miss_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int nch  [2] = '{4, 3};
    int cmax [2] = '{255, 3};
    int cw   [2] = '{8, 2};

    // Reference state: per-channel pending/count, plus the levels sampled on recent edges.
    int m_pend [2][4];
    int m_cnt  [2][4];
    int m_err  [2];
    int m_hist [2][4][SYNC+1];
    int hold   [2][4];

    task automatic check_eq(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // An event is seen when the level sampled SYNC edges ago is high and the one before is low.
    task automatic model_edge(int d);
        int valid;
        int rise;
        int vack;
        if (reset) begin
            for (int ch = 0; ch < 4; ch++) begin
                m_pend[d][ch] = 0;
                m_cnt[d][ch]  = 0;
                for (int k = 0; k <= SYNC; k++) m_hist[d][ch][k] = 0;
            end
            m_err[d] = 0;
        end else begin
            valid = 0;
            if (av[d] && (int'(aid[d]) < nch[d]) && (m_pend[d][aid[d]] != 0)) valid = 1;
            m_err[d] = (av[d] && valid == 0) ? 1 : 0;
            for (int ch = 0; ch < nch[d]; ch++) begin
                rise = (m_hist[d][ch][SYNC-1] != 0 && m_hist[d][ch][SYNC] == 0) ? 1 : 0;
                vack = (valid != 0 && int'(aid[d]) == ch) ? 1 : 0;
                if (clr[d]) m_cnt[d][ch] = 0;
                else if (rise != 0 && m_pend[d][ch] != 0 && vack == 0 && m_cnt[d][ch] < cmax[d])
                    m_cnt[d][ch]++;
                if (rise != 0) m_pend[d][ch] = 1;
                else if (vack != 0) m_pend[d][ch] = 0;
                for (int k = SYNC; k >= 1; k--) m_hist[d][ch][k] = m_hist[d][ch][k-1];
                m_hist[d][ch][0] = int'(evt[d][ch]);
            end
        end
    endtask

    task automatic check_all();
        for (int d = 0; d < 2; d++) begin
            logic [31:0] ep, em, ei, eid;
            logic [31:0] op, om, oi, oid, oe;
            bit found;
            string nm;
            ep = 0; em = 0; ei = 0; eid = 0; found = 0;
            nm = (d == 0) ? "A" : "B";
            for (int ch = 0; ch < nch[d]; ch++) begin
                if (m_pend[d][ch] != 0) begin
                    ep = ep | (32'd1 << ch);
                    if (!mask[d][ch]) begin
                        ei = 1;
                        if (!found) begin
                            eid   = ch;
                            found = 1;
                        end
                    end
                end
                em = em | (32'(m_cnt[d][ch]) << (ch * cw[d]));
            end
            op  = (d == 0) ? 32'(pend_a) : 32'(pend_b);
            om  = (d == 0) ? miss_a : 32'(miss_b);
            oi  = (d == 0) ? 32'(irq_a) : 32'(irq_b);
            oid = (d == 0) ? 32'(id_a) : 32'(id_b);
            oe  = (d == 0) ? 32'(err_a) : 32'(err_b);
            check_eq({nm, " pending"}, op, ep);
            check_eq({nm, " irq"}, oi, ei);
            check_eq({nm, " irq_id"}, oid, eid);
            check_eq({nm, " ack_err"}, oe, 32'(m_err[d]));
            check_eq({nm, " miss_cnt"}, om, em);
        end
    endtask

    task automatic step();
        @(posedge clk50);
        model_edge(0);
        model_edge(1);
        @(negedge clk50);
        check_all();
    endtask

    task automatic pulse(int d, int ch);
        evt[d][ch] = 1'b1;
        repeat (3) step();
        evt[d][ch] = 1'b0;
        repeat (3) step();
    endtask

    initial begin
        reset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            evt[d] = '0; mask[d] = '0; av[d] = 1'b0; aid[d] = '0; clr[d] = 1'b0;
        end
        step();
        step();

        // Level high from the first edge after reset latches on edge 3.
        reset = 1'b0;
        evt[0][2] = 1'b1;
        step();
        step();
        check_eq("A pending before latency", 32'(pend_a), 32'h0);
        step();
        check_eq("A pending ch2", 32'(pend_a), 32'h4);
        check_eq("A irq ch2", 32'(irq_a), 32'h1);
        check_eq("A irq_id ch2", 32'(id_a), 32'h2);
        av[0] = 1'b1; aid[0] = 2'd2;
        step();
        av[0] = 1'b0;
        check_eq("A pending after ack2", 32'(pend_a), 32'h0);
        check_eq("A irq after ack2", 32'(irq_a), 32'h0);
        check_eq("A ack_err after ack2", 32'(err_a), 32'h0);

        // Simultaneous rises on 1 and 3, then masking and acking.
        evt[0][1] = 1'b1; evt[0][3] = 1'b1;
        repeat (3) step();
        check_eq("A pending ch1+3", 32'(pend_a), 32'ha);
        check_eq("A irq_id ch1+3", 32'(id_a), 32'h1);
        mask[0][1] = 1'b1;
        #1;
        check_eq("A irq_id masked", 32'(id_a), 32'h3);
        check_all();
        av[0] = 1'b1; aid[0] = 2'd3;
        step();
        av[0] = 1'b0;
        check_eq("A irq after ack3", 32'(irq_a), 32'h0);
        check_eq("A pending after ack3", 32'(pend_a), 32'h2);

        // Missed events and saturation.
        repeat (4) pulse(0, 0);
        check_eq("A miss ch0", 32'(miss_a[7:0]), 32'd3);
        repeat (6) pulse(1, 0);
        check_eq("B miss ch0 saturated", 32'(miss_b[1:0]), 32'd3);
        evt[1][0] = 1'b1;
        step();
        step();
        clr[1] = 1'b1;
        step();
        clr[1] = 1'b0;
        check_eq("B miss after clr", 32'(miss_b), 32'd0);
        check_eq("B pending ch0 held", 32'(pend_b[0]), 32'd1);
        evt[1][0] = 1'b0;
        repeat (3) step();

        // Rise coinciding with a valid ack of the same channel.
        evt[0][1] = 1'b0;
        repeat (3) step();
        evt[0][1] = 1'b1;
        step();
        step();
        av[0] = 1'b1; aid[0] = 2'd1;
        step();
        av[0] = 1'b0;
        check_eq("A pending ch1 rise+ack", 32'(pend_a[1]), 32'd1);
        check_eq("A miss ch1 rise+ack", 32'(miss_a[15:8]), 32'd0);
        check_eq("A ack_err rise+ack", 32'(err_a), 32'd0);

        // Invalid acks: target not pending, and out-of-range id.
        av[0] = 1'b1; aid[0] = 2'd1;
        step();
        step();
        av[0] = 1'b0;
        check_eq("A ack_err not pending", 32'(err_a), 32'd1);
        check_eq("A pending ch1 cleared", 32'(pend_a[1]), 32'd0);
        step();
        check_eq("A ack_err one cycle", 32'(err_a), 32'd0);
        av[1] = 1'b1; aid[1] = 2'd3;
        step();
        av[1] = 1'b0;
        check_eq("B ack_err id out of range", 32'(err_b), 32'd1);
        step();
        check_eq("B ack_err one cycle", 32'(err_b), 32'd0);

        // Reset in the middle of activity, then re-latch of held levels.
        evt[0] = 4'h0;
        repeat (3) step();
        evt[0] = 4'hf;
        repeat (3) step();
        check_eq("A pending all", 32'(pend_a), 32'hf);
        check_eq("A miss before reset", miss_a, 32'h4);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_eq("A pending after reset", 32'(pend_a), 32'h0);
        check_eq("A miss after reset", miss_a, 32'h0);
        check_eq("A irq after reset", 32'(irq_a), 32'h0);
        step();
        step();
        check_eq("A pending 2 edges after reset", 32'(pend_a), 32'h0);
        step();
        check_eq("A pending relatch", 32'(pend_a), 32'hf);

        // Randomised traffic honouring the minimum level width.
        for (int d = 0; d < 2; d++) for (int ch = 0; ch < 4; ch++) hold[d][ch] = 0;
        repeat (600) begin
            for (int d = 0; d < 2; d++) begin
                for (int ch = 0; ch < nch[d]; ch++) begin
                    if (hold[d][ch] == 0 && $urandom_range(0, 1) == 1) begin
                        evt[d][ch]  = ~evt[d][ch];
                        hold[d][ch] = 3 + int'($urandom_range(0, 3));
                    end
                end
                mask[d] = 4'($urandom);
                av[d]   = ($urandom_range(0, 2) == 0);
                aid[d]  = 2'($urandom_range(0, 3));
                clr[d]  = ($urandom_range(0, 31) == 0);
            end
            reset = ($urandom_range(0, 99) == 0);
            step();
            for (int d = 0; d < 2; d++)
                for (int ch = 0; ch < 4; ch++)
                    if (hold[d][ch] > 0) hold[d][ch]--;
        end

        reset = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
